tratamento_botoes_multi: RTL

//  N-channel board-button conditioner: synchronises raw push-buttons, debounces each one with a counter FSM,

---
 rtl/botoes_pkg.sv | 19 +
 rtl/tratamento_botoes_multi_if.sv | 16 +
 rtl/debounce_canal.sv | 150 +++++++++++++++
 rtl/tratamento_botoes_multi.sv | 63 ++++++
 4 files changed

// File: rtl/botoes_pkg.sv
// Shared definitions for the multi-channel button conditioner.
//   estado_t : per-channel debounce FSM state (2-bit encoding)
//   maxU     : helper used by elaboration-time width checks
package botoes_pkg;

    localparam int unsigned ESTADO_W = 2;

    typedef enum logic [ESTADO_W-1:0] {
        SOLTO       = 2'b00,
        CONF_ALTA   = 2'b01,
        PRESSIONADO = 2'b10,
        CONF_BAIXA  = 2'b11
    } estado_t;

    function automatic int unsigned maxU(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tratamento_botoes_multi_if.sv
// Button bundle between board pins and the conditioner.
//   botaoPlaca : raw asynchronous pins (driven by the board side)
//   pulso      : one-cycle pulse per confirmed press / auto-repeat
//   nivel      : debounced level, 1 = pressed
//   solto      : one-cycle pulse per confirmed release
interface tratamento_botoes_multi_if #(
    parameter int unsigned N_BOTOES = 4
);
    logic [N_BOTOES-1:0] botaoPlaca;
    logic [N_BOTOES-1:0] pulso;
    logic [N_BOTOES-1:0] nivel;
    logic [N_BOTOES-1:0] solto;

    modport master (output botaoPlaca, input pulso, input nivel, input solto);
    modport slave  (input botaoPlaca, output pulso, output nivel, output solto);
endinterface

// File: rtl/debounce_canal.sv
// One button channel: 2-FF synchroniser, polarity normalise, debounce FSM and
// optional auto-repeat scheduler.
//   clock, reset : system clock, synchronous active-high reset
//   botaoBruto   : raw asynchronous pin
//   pulso        : registered one-cycle press / repeat pulse
//   nivel        : registered debounced level (1 = pressed)
//   solto        : registered one-cycle release pulse
module debounce_canal
    import botoes_pkg::*;
#(
    parameter int unsigned ATIVO_BAIXO = 1,
    parameter int unsigned CICLOS_DEB  = 50000,
    parameter int unsigned CONT_W      = 17,
    parameter int unsigned REPETE      = 0,
    parameter int unsigned CICLOS_REP1 = 25000000,
    parameter int unsigned CICLOS_REPN = 5000000,
    parameter int unsigned REP_W       = 25
) (
    input  logic clock,
    input  logic reset,
    input  logic botaoBruto,
    output logic pulso,
    output logic nivel,
    output logic solto
);

    localparam logic              REPOUSO  = 1'(ATIVO_BAIXO != 0);
    localparam logic              REP_ON   = 1'(REPETE != 0);
    localparam logic [CONT_W-1:0] CNT_FIM  = CONT_W'(CICLOS_DEB - 1);
    localparam logic [REP_W-1:0]  REP_FIM1 = REP_W'(CICLOS_REP1 - 1);
    localparam logic [REP_W-1:0]  REP_FIMN = REP_W'(CICLOS_REPN - 1);

    logic sync1, sync2, s;

    estado_t           estado, estadoProx;
    logic [CONT_W-1:0] cnt, cntProx;
    logic [REP_W-1:0]  rep, repProx, repAlvo, repAvanca;
    logic              jaRepetiu, jaRepetiuProx;
    logic              pulsoProx, nivelProx, soltoProx;

    // Synchroniser resets to the idle pin level so a held button is not seen until after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= REPOUSO;
            sync2 <= REPOUSO;
        end else begin
            sync1 <= botaoBruto;
            sync2 <= sync1;
        end
    end

    assign s = REPOUSO ? ~sync2 : sync2;

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= SOLTO;
            cnt       <= '0;
            rep       <= '0;
            jaRepetiu <= 1'b0;
            pulso     <= 1'b0;
            nivel     <= 1'b0;
            solto     <= 1'b0;
        end else begin
            estado    <= estadoProx;
            cnt       <= cntProx;
            rep       <= repProx;
            jaRepetiu <= jaRepetiuProx;
            pulso     <= pulsoProx;
            nivel     <= nivelProx;
            solto     <= soltoProx;
        end
    end

    // Repeat target switches from the first-delay to the interval after the first repeat;
    // the counter saturates at the target instead of wrapping.
    always_comb begin
        repAlvo   = jaRepetiu ? REP_FIMN : REP_FIM1;
        repAvanca = (rep < repAlvo) ? rep + REP_W'(1) : rep;
    end

    // Next-state and output logic.
    always_comb begin
        estadoProx    = estado;
        cntProx       = cnt;
        repProx       = rep;
        jaRepetiuProx = jaRepetiu;
        pulsoProx     = 1'b0;
        soltoProx     = 1'b0;
        nivelProx     = nivel;

        case (estado)
            SOLTO: begin
                cntProx = '0;
                if (s) estadoProx = CONF_ALTA;
            end
            CONF_ALTA: begin
                if (!s) begin
                    estadoProx = SOLTO;
                    cntProx    = '0;
                end else if (cnt == CNT_FIM) begin
                    estadoProx    = PRESSIONADO;
                    cntProx       = '0;
                    pulsoProx     = 1'b1;
                    nivelProx     = 1'b1;
                    repProx       = '0;
                    jaRepetiuProx = 1'b0;
                end else begin
                    cntProx = cnt + CONT_W'(1);
                end
            end
            PRESSIONADO: begin
                if (!s) begin
                    estadoProx = CONF_BAIXA;
                    cntProx    = '0;
                    if (REP_ON) repProx = repAvanca;
                end else if (REP_ON) begin
                    if (rep >= repAlvo) begin
                        pulsoProx     = 1'b1;
                        repProx       = '0;
                        jaRepetiuProx = 1'b1;
                    end else begin
                        repProx = repAvanca;
                    end
                end
            end
            CONF_BAIXA: begin
                // A bounce back to pressed keeps the repeat schedule running.
                if (s) begin
                    estadoProx = PRESSIONADO;
                    cntProx    = '0;
                    if (REP_ON) repProx = repAvanca;
                end else if (cnt == CNT_FIM) begin
                    estadoProx = SOLTO;
                    cntProx    = '0;
                    soltoProx  = 1'b1;
                    nivelProx  = 1'b0;
                end else begin
                    cntProx = cnt + CONT_W'(1);
                    if (REP_ON) repProx = repAvanca;
                end
            end
            default: begin
                estadoProx = SOLTO;
                cntProx    = '0;
            end
        endcase
    end

endmodule

// File: rtl/tratamento_botoes_multi.sv
// N-channel push-button conditioner: one debounce_canal per button.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : botaoPlaca in; pulso / nivel / solto out, one bit per channel
module tratamento_botoes_multi
    import botoes_pkg::*;
#(
    parameter int unsigned N_BOTOES    = 4,
    parameter int unsigned ATIVO_BAIXO = 1,
    parameter int unsigned CICLOS_DEB  = 50000,
    parameter int unsigned CONT_W      = 17,
    parameter int unsigned REPETE      = 0,
    parameter int unsigned CICLOS_REP1 = 25000000,
    parameter int unsigned CICLOS_REPN = 5000000,
    parameter int unsigned REP_W       = 25
) (
    input  logic                  clock,
    input  logic                  reset,
    tratamento_botoes_multi_if.slave bus
);

    // Elaboration-time parameter checks.
    if (N_BOTOES < 1 || N_BOTOES > 16) begin : gErroN
        $error("N_BOTOES must be in 1..16");
    end
    if (CICLOS_DEB < 2) begin : gErroDeb
        $error("CICLOS_DEB must be >= 2");
    end
    if ((64'(1) << CONT_W) <= 64'(CICLOS_DEB)) begin : gErroContW
        $error("CONT_W too small for CICLOS_DEB");
    end
    if (REPETE != 0 && (CICLOS_REP1 < 1 || CICLOS_REPN < 1)) begin : gErroRep
        $error("CICLOS_REP1 and CICLOS_REPN must be >= 1");
    end
    if (REPETE != 0 && (64'(1) << REP_W) <= 64'(maxU(CICLOS_REP1, CICLOS_REPN))) begin : gErroRepW
        $error("REP_W too small for repeat intervals");
    end

    logic [N_BOTOES-1:0] pulsoV, nivelV, soltoV;

    for (genvar i = 0; i < N_BOTOES; i++) begin : gCanal
        debounce_canal #(
            .ATIVO_BAIXO (ATIVO_BAIXO),
            .CICLOS_DEB  (CICLOS_DEB),
            .CONT_W      (CONT_W),
            .REPETE      (REPETE),
            .CICLOS_REP1 (CICLOS_REP1),
            .CICLOS_REPN (CICLOS_REPN),
            .REP_W       (REP_W)
        ) uCanal (
            .clock      (clock),
            .reset      (reset),
            .botaoBruto (bus.botaoPlaca[i]),
            .pulso      (pulsoV[i]),
            .nivel      (nivelV[i]),
            .solto      (soltoV[i])
        );
    end

    assign bus.pulso = pulsoV;
    assign bus.nivel = nivelV;
    assign bus.solto = soltoV;

endmodule
